// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory for the MEM stage: sized stores,
// sign/zero-extended registered loads, fault flags and a post-reset clear sweep.
module data_mem_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   Write_Data,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [1:0]    Size,
  input  logic          Unsigned,
  output logic [31:0]   Read_Data,
  output logic          Read_Valid,
  output logic          Ready,
  output logic          Misaligned,
  output logic          Out_Of_Range
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [IDXW-1:0] clr_idx;
  logic [31:0]     mem [DEPTH];

  logic [IDXW-1:0] widx;
  logic [1:0]      lane;
  logic            req, oor, mis, ok;
  logic            we;
  logic [IDXW-1:0] wr_idx;
  logic [3:0]      be;
  logic [31:0]     wdat;
  logic [31:0]     rword, rext;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;

  always_comb begin
    widx  = Address[IDXW+1:2];
    lane  = Address[1:0];
    req   = MemRead | MemWrite;
    oor   = |Address[AW-1:IDXW+2];
    mis   = (Size == 2'b01 && Address[0]) ||
            (Size == 2'b10 && lane != 2'b00) ||
            (Size == 2'b11);
    ok    = (state == RUN) && req && !oor && !mis;

    // The clear sweep shares the single write port with normal stores.
    we     = '0;
    wr_idx = widx;
    be     = '0;
    wdat   = Write_Data;
    if (rst_n) begin
      if (state == CLEAR) begin
        we     = 1'b1;
        wr_idx = clr_idx;
        be     = '1;
        wdat   = '0;
      end else if (ok && MemWrite) begin
        we = 1'b1;
        unique case (Size)
          2'b00: begin
            be   = 4'b0001 << lane;
            wdat = {4{Write_Data[7:0]}};
          end
          2'b01: begin
            be   = Address[1] ? 4'b1100 : 4'b0011;
            wdat = {2{Write_Data[15:0]}};
          end
          default: be = '1;
        endcase
      end
    end

    rword = mem[widx];
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = rword[{Address[1], 4'b0000} +: 16];
    unique case (Size)
      2'b00:   rext = Unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   rext = Unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: rext = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[wr_idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  // Load reads the pre-edge array contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      Ready        <= 1'b0;
      Read_Data    <= '0;
      Read_Valid   <= 1'b0;
      Misaligned   <= 1'b0;
      Out_Of_Range <= 1'b0;
    end else begin
      Read_Valid   <= 1'b0;
      Misaligned   <= 1'b0;
      Out_Of_Range <= 1'b0;
      unique case (state)
        CLEAR: begin
          if (clr_idx == IDXW'(DEPTH - 1)) begin
            state <= RUN;
            Ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN: begin
          if (req) begin
            Misaligned   <= mis;
            Out_Of_Range <= oor;
          end
          if (ok && MemRead) begin
            Read_Data  <= rext;
            Read_Valid <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with DEPTH = 256.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic        MemWrite, MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Read_Data;
  logic        Read_Valid, Ready, Misaligned, Out_Of_Range;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
    .Read_Data(Read_Data), .Read_Valid(Read_Valid), .Ready(Ready),
    .Misaligned(Misaligned), .Out_Of_Range(Out_Of_Range)
  );

  // Drive one request across a posedge; returns at the following negedge.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u);
    MemRead = rd; MemWrite = wr; Address = a; Write_Data = d; Size = sz; Unsigned = u;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle();
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
  endtask

  // Holds MemRead @0 while sweeping; counts edges until Ready, flags early Read_Valid.
  task automatic sweep(output int edges, output int early_rv);
    edges = 0; early_rv = 0;
    MemRead = 1'b1; Address = 32'h0; Size = 2'b10; Unsigned = 1'b0;
    while (!Ready && edges < 400) begin
      @(negedge clk);
      edges++;
      if (Read_Valid || Misaligned || Out_Of_Range) early_rv++;
    end
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    int edges, early;
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; Address = 0; Write_Data = 0; Size = 0; Unsigned = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Ready, Read_Valid, Misaligned, Out_Of_Range} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {Ready, Read_Valid, Misaligned, Out_Of_Range});
    end
    checks++;
    if (Read_Data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", Read_Data); end
    rst_n = 1'b1;
    sweep(edges, early);
    checks++;
    if (edges !== 256) begin errors++; $display("FAIL ready_latency got %0d want 256", edges); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL activity_in_clear got %0d want 0", early); end
    do_op(1, 0, 32'h0, 0, 2'b10, 0);
    checks++;
    if (Read_Valid !== 1'b1 || Read_Data !== 32'h0) begin
      errors++; $display("FAIL first_load got rv=%b %h want rv=1 00000000", Read_Valid, Read_Data);
    end
    idle();
    checks++;
    if (Read_Valid !== 1'b0) begin errors++; $display("FAIL rv_drop got %b want 0", Read_Valid); end
  endtask

  task automatic test_load_ext();
    do_op(0, 1, 32'h10, 32'h8899AABB, 2'b10, 0);
    do_op(1, 0, 32'h13, 0, 2'b00, 0);
    checks++;
    if (Read_Valid !== 1'b1 || Read_Data !== 32'hFFFFFF88) begin
      errors++; $display("FAIL lb got rv=%b %h want rv=1 ffffff88", Read_Valid, Read_Data);
    end
    do_op(1, 0, 32'h13, 0, 2'b00, 1);
    checks++;
    if (Read_Data !== 32'h00000088) begin errors++; $display("FAIL lbu got %h want 00000088", Read_Data); end
    do_op(1, 0, 32'h10, 0, 2'b01, 0);
    checks++;
    if (Read_Data !== 32'hFFFFAABB) begin errors++; $display("FAIL lh got %h want ffffaabb", Read_Data); end
    do_op(1, 0, 32'h12, 0, 2'b01, 1);
    checks++;
    if (Read_Data !== 32'h00008899) begin errors++; $display("FAIL lhu got %h want 00008899", Read_Data); end
    do_op(1, 0, 32'h11, 0, 2'b00, 0);
    checks++;
    if (Read_Data !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_lane1 got %h want ffffffaa", Read_Data); end
    do_op(1, 0, 32'h10, 0, 2'b00, 0);
    checks++;
    if (Read_Data !== 32'hFFFFFFBB) begin errors++; $display("FAIL lb_lane0 got %h want ffffffbb", Read_Data); end
  endtask

  task automatic test_partial_store();
    do_op(0, 1, 32'h20, 32'h11223344, 2'b10, 0);
    do_op(0, 1, 32'h21, 32'hFFFFFF5A, 2'b00, 0);
    do_op(1, 0, 32'h20, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'h11225A44) begin errors++; $display("FAIL sb_merge got %h want 11225a44", Read_Data); end
    do_op(0, 1, 32'h22, 32'h1234BEEF, 2'b01, 0);
    do_op(1, 0, 32'h20, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'hBEEF5A44) begin errors++; $display("FAIL sh_merge got %h want beef5a44", Read_Data); end
    do_op(0, 1, 32'h20, 32'h000000C3, 2'b00, 0);
    do_op(1, 0, 32'h20, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'hBEEF5AC3) begin errors++; $display("FAIL sb_lane0 got %h want beef5ac3", Read_Data); end
  endtask

  task automatic test_faults();
    do_op(1, 0, 32'h10, 0, 2'b10, 0);
    do_op(1, 0, 32'h06, 0, 2'b10, 0);
    checks++;
    if ({Misaligned, Out_Of_Range, Read_Valid} !== 3'b100 || Read_Data !== 32'h8899AABB) begin
      errors++; $display("FAIL misaligned_lw got mis/oor/rv=%b %h want 100 8899aabb",
                         {Misaligned, Out_Of_Range, Read_Valid}, Read_Data);
    end
    idle();
    checks++;
    if (Misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", Misaligned); end
    do_op(0, 1, 32'h400, 32'hDEADBEEF, 2'b10, 0);
    checks++;
    if ({Misaligned, Out_Of_Range} !== 2'b01) begin
      errors++; $display("FAIL oor_sw got mis/oor=%b want 01", {Misaligned, Out_Of_Range});
    end
    do_op(1, 0, 32'h0, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'h0 || Out_Of_Range !== 1'b0) begin
      errors++; $display("FAIL no_corrupt got %h oor=%b want 00000000 oor=0", Read_Data, Out_Of_Range);
    end
    do_op(1, 0, 32'h21, 0, 2'b01, 0);
    checks++;
    if ({Misaligned, Read_Valid} !== 2'b10) begin
      errors++; $display("FAIL mis_half got mis/rv=%b want 10", {Misaligned, Read_Valid});
    end
    do_op(1, 0, 32'h20, 0, 2'b11, 0);
    checks++;
    if (Misaligned !== 1'b1) begin errors++; $display("FAIL size11 got %b want 1", Misaligned); end
    do_op(1, 0, 32'h402, 0, 2'b10, 0);
    checks++;
    if ({Misaligned, Out_Of_Range, Read_Valid} !== 3'b110) begin
      errors++; $display("FAIL both_flags got mis/oor/rv=%b want 110", {Misaligned, Out_Of_Range, Read_Valid});
    end
    do_op(0, 1, 32'h3FC, 32'hCAFEF00D, 2'b10, 0);
    do_op(1, 0, 32'h3FC, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'hCAFEF00D || Out_Of_Range !== 1'b0) begin
      errors++; $display("FAIL last_word got %h oor=%b want cafef00d oor=0", Read_Data, Out_Of_Range);
    end
  endtask

  task automatic test_back_to_back();
    do_op(0, 1, 32'h30, 32'h1, 2'b10, 0);
    do_op(1, 1, 32'h30, 32'h2, 2'b10, 0);
    checks++;
    if (Read_Valid !== 1'b1 || Read_Data !== 32'h1) begin
      errors++; $display("FAIL rbw got rv=%b %h want rv=1 00000001", Read_Valid, Read_Data);
    end
    do_op(1, 0, 32'h30, 0, 2'b10, 0);
    checks++;
    if (Read_Data !== 32'h2) begin errors++; $display("FAIL after_rbw got %h want 00000002", Read_Data); end
  endtask

  task automatic test_reset_mid();
    int edges, early, bad;
    do_op(0, 1, 32'h44, 32'h55667788, 2'b10, 0);
    repeat (3) idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({Ready, Read_Valid} !== 2'b00 || Read_Data !== 32'h0) begin
      errors++; $display("FAIL run_reset got rdy/rv=%b %h want 00 00000000", {Ready, Read_Valid}, Read_Data);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep(edges, early);
    checks++;
    if (edges !== 256 || early !== 0) begin
      errors++; $display("FAIL clear_restart got edges=%0d early=%0d want 256 0", edges, early);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      do_op(1, 0, 32'(i * 4), 0, 2'b10, 0);
      if (Read_Valid !== 1'b1 || Read_Data !== 32'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sweep_zero got %0d nonzero words want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_partial_store();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
